// File: rtl/obi2axi_pkg.sv
// Shared types and AXI encodings for the OBI-to-AXI bridge.
// Holds the bridge FSM state enum and the fixed AXI field values it drives.
package obi2axi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_RSP = 3'd2,
    RD_REQ = 3'd3,
    RD_RSP = 3'd4
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/obi2axi_if.sv
// AXI4 bus between the bridge (Master) and the AXI memory (Slave).
// All five channels; user fields carried but not interpreted.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/obi2axi_bridge.sv
// OBI to single-beat AXI4 bridge, one outstanding transaction; OBI2AXI_ERR_EN maps resp[1] onto err_o.
// Latency: gnt same cycle as req in IDLE, AXI request next cycle, rvalid_o one cycle after b/r handshake.
// Backpressure: gnt_o held low while a transaction is in flight; AXI valids hold payload until ready.
module obi2axi_bridge
  import obi2axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic                        we_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  AXI_BUS.Master                      axi_mst
);

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH/8-1:0] be_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic                        rvalid_q;
  logic                        capture, rsp_fire, rd_fire, rsp_err;
  logic                        aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic                        unused_in;

  always_comb begin
    state_d   = state_q;
    gnt_o     = 1'b0;
    capture   = 1'b0;
    rsp_fire  = 1'b0;
    rd_fire   = 1'b0;
    rsp_err   = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    ar_valid  = 1'b0;
    b_ready   = 1'b0;
    r_ready   = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          capture   = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = we_i ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; each valid drops after its own handshake
        aw_valid = !aw_done_q;
        w_valid  = !w_done_q;
        if (aw_valid && axi_mst.aw_ready) aw_done_d = 1'b1;
        if (w_valid && axi_mst.w_ready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)        state_d   = WR_RSP;
      end
      WR_RSP: begin
        b_ready = 1'b1;
        if (axi_mst.b_valid) begin
          rsp_fire = 1'b1;
          rsp_err  = axi_mst.b_resp[1];
          state_d  = IDLE;
        end
      end
      RD_REQ: begin
        ar_valid = 1'b1;
        if (axi_mst.ar_ready) state_d = RD_RSP;
      end
      RD_RSP: begin
        r_ready = 1'b1;
        if (axi_mst.r_valid && axi_mst.r_last) begin
          rsp_fire = 1'b1;
          rd_fire  = 1'b1;
          rsp_err  = axi_mst.r_resp[1];
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rsp_fire;
      if (capture) begin
        addr_q  <= {addr_i[AXI_ADDR_WIDTH-1:2], 2'b00};
        be_q    <= be_i;
        wdata_q <= wdata_i;
      end
      if (rd_fire) rdata_q <= axi_mst.r_data;
    end
  end

`ifdef OBI2AXI_ERR_EN
  logic err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= rsp_fire && rsp_err;
  end
  assign err_o = err_q;
`else
  logic unused_err;
  assign unused_err = rsp_err;
  assign err_o      = 1'b0;
`endif

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

  assign axi_mst.aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign axi_mst.aw_addr   = addr_q;
  assign axi_mst.aw_len    = 8'd0;
  assign axi_mst.aw_size   = AXI_SIZE_4B;
  assign axi_mst.aw_burst  = AXI_BURST_INCR;
  assign axi_mst.aw_lock   = 1'b0;
  assign axi_mst.aw_cache  = 4'b0000;
  assign axi_mst.aw_prot   = 3'b000;
  assign axi_mst.aw_qos    = 4'd0;
  assign axi_mst.aw_region = 4'd0;
  assign axi_mst.aw_user   = '0;
  assign axi_mst.aw_valid  = aw_valid;

  assign axi_mst.w_data    = wdata_q;
  assign axi_mst.w_strb    = be_q;
  assign axi_mst.w_last    = 1'b1;
  assign axi_mst.w_user    = '0;
  assign axi_mst.w_valid   = w_valid;

  assign axi_mst.b_ready   = b_ready;

  assign axi_mst.ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign axi_mst.ar_addr   = addr_q;
  assign axi_mst.ar_len    = 8'd0;
  assign axi_mst.ar_size   = AXI_SIZE_4B;
  assign axi_mst.ar_burst  = AXI_BURST_INCR;
  assign axi_mst.ar_lock   = 1'b0;
  assign axi_mst.ar_cache  = 4'b0000;
  assign axi_mst.ar_prot   = 3'b000;
  assign axi_mst.ar_qos    = 4'd0;
  assign axi_mst.ar_region = 4'd0;
  assign axi_mst.ar_user   = '0;
  assign axi_mst.ar_valid  = ar_valid;

  assign axi_mst.r_ready   = r_ready;

  // IDs and user echoes are irrelevant with a single outstanding transaction
  assign unused_in = ^{addr_i[1:0], axi_mst.b_id, axi_mst.r_id, axi_mst.b_user,
                       axi_mst.r_user, axi_mst.b_resp[0], axi_mst.r_resp[0]};

endmodule

// File: tb/tb_obi2axi_bridge.sv
// Bench for obi2axi_bridge: OBI driver, behavioural AXI RAM slave, scoreboard on OBI responses.
module tb_obi2axi_bridge;
  import obi2axi_pkg::*;

`ifdef OBI2AXI_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic        chk_data;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } axi_exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i, gnt_o, we_i, rvalid_o, err_o;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic [3:0]  be_i;

  int checks = 0;
  int errors = 0;

  rsp_t     rsp_q[$];
  axi_exp_t axi_q[$];
  rsp_t     mon_e;

  logic [31:0] mem [0:255];
  int          aw_stall;
  logic [1:0]  bresp_inj, rresp_inj;
  logic        r_hold;

  always #5 clk_i = ~clk_i;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(16), .AXI_USER_WIDTH(10)) axi ();

  obi2axi_bridge #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(16), .AXI_USER_WIDTH(10), .AXI_ID(0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .axi_mst(axi)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard: every rvalid_o pulse must match the oldest expected response
  always @(negedge clk_i) begin
    if (rvalid_o) begin
      if (rsp_q.size() == 0) fail("unexpected_rvalid");
      else begin
        mon_e = rsp_q.pop_front();
        chk("rsp_err", {31'd0, err_o}, {31'd0, mon_e.err});
        if (mon_e.chk_data) chk("rsp_rdata", rdata_o, mon_e.rdata);
      end
    end
  end

  // AXI RAM slave: sample at negedge, update at posedge+1
  initial begin
    logic s_aw, s_w, s_b, s_ar, s_r, stall_seen;
    logic aw_got, w_got, rd_pend, busy, wr_open, hold_vld;
    logic [31:0] aw_a, w_d, ar_a, hold_addr;
    logic [3:0]  w_s;
    int aw_cnt, w_cnt;
    axi_exp_t e;
    aw_got = 0; w_got = 0; rd_pend = 0; busy = 0; wr_open = 0; hold_vld = 0;
    aw_a = 0; w_d = 0; ar_a = 0; hold_addr = 0; w_s = 0; aw_cnt = 0; w_cnt = 0;
    axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.ar_ready = 1'b1;
    axi.b_valid = 1'b0; axi.b_resp = 2'b00; axi.b_id = '0; axi.b_user = '0;
    axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = 2'b00; axi.r_last = 1'b0;
    axi.r_id = '0; axi.r_user = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        aw_got = 0; w_got = 0; rd_pend = 0; busy = 0; wr_open = 0; hold_vld = 0;
        aw_cnt = 0; w_cnt = 0;
        @(posedge clk_i); #1;
        axi.b_valid = 1'b0; axi.r_valid = 1'b0; axi.r_last = 1'b0;
        axi.aw_ready = (aw_stall == 0);
        continue;
      end
      s_aw = axi.aw_valid && axi.aw_ready;
      s_w  = axi.w_valid && axi.w_ready;
      s_b  = axi.b_valid && axi.b_ready;
      s_ar = axi.ar_valid && axi.ar_ready;
      s_r  = axi.r_valid && axi.r_ready;
      stall_seen = axi.aw_valid && !axi.aw_ready;
      if (axi.aw_valid && hold_vld) chk("aw_addr_stable", axi.aw_addr, hold_addr);
      if (stall_seen) begin hold_addr = axi.aw_addr; hold_vld = 1; end
      else hold_vld = 0;
      if (s_ar) begin
        if (busy) fail("overlap_ar");
        busy = 1; rd_pend = 1; ar_a = axi.ar_addr;
        chk("ar_len", {24'd0, axi.ar_len}, 32'd0);
        chk("ar_size", {29'd0, axi.ar_size}, 32'd2);
        chk("ar_burst", {30'd0, axi.ar_burst}, 32'd1);
        if (axi_q.size() == 0) fail("ar_no_expect");
        else begin e = axi_q.pop_front(); chk("ar_addr", axi.ar_addr, e.addr); end
      end
      if ((s_aw || s_w) && !wr_open) begin
        if (busy) fail("overlap_wr");
        busy = 1; wr_open = 1;
      end
      if (s_aw) begin
        aw_got = 1; aw_a = axi.aw_addr; aw_cnt++;
        chk("aw_len", {24'd0, axi.aw_len}, 32'd0);
        chk("aw_size", {29'd0, axi.aw_size}, 32'd2);
      end
      if (s_w) begin
        w_got = 1; w_d = axi.w_data; w_s = axi.w_strb; w_cnt++;
        chk("w_last", {31'd0, axi.w_last}, 32'd1);
      end
      if (s_b) begin
        chk("aw_beats", aw_cnt, 1);
        chk("w_beats", w_cnt, 1);
        aw_cnt = 0; w_cnt = 0; busy = 0; wr_open = 0;
      end
      if (s_r) begin busy = 0; rd_pend = 0; end
      @(posedge clk_i); #1;
      if (stall_seen && aw_stall > 0) aw_stall--;
      axi.aw_ready = (aw_stall == 0);
      if (s_b) axi.b_valid = 1'b0;
      if (s_r) begin axi.r_valid = 1'b0; axi.r_last = 1'b0; end
      if (aw_got && w_got) begin
        if (axi_q.size() == 0) fail("wr_no_expect");
        else begin
          e = axi_q.pop_front();
          chk("aw_addr", aw_a, e.addr);
          chk("w_strb", {28'd0, w_s}, {28'd0, e.strb});
          chk("w_data", w_d, e.data);
        end
        for (int b = 0; b < 4; b++)
          if (w_s[b]) mem[aw_a[9:2]][8*b +: 8] = w_d[8*b +: 8];
        axi.b_valid = 1'b1; axi.b_resp = bresp_inj;
        aw_got = 0; w_got = 0;
      end
      if (rd_pend && !axi.r_valid && !r_hold) begin
        axi.r_valid = 1'b1; axi.r_last = 1'b1;
        axi.r_data = mem[ar_a[9:2]]; axi.r_resp = rresp_inj;
      end
    end
  end

  task automatic obi_xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input logic exp_rsp);
    int n;
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
    for (n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (gnt_o) break;
    end
    if (n == 50) begin
      fail("gnt_timeout");
      @(posedge clk_i); #1; req_i = 1'b0;
      return;
    end
    axi_q.push_back('{addr: {addr[31:2], 2'b00}, strb: be, data: wd});
    if (exp_rsp) rsp_q.push_back('{chk_data: !we, rdata: exp_rd, err: exp_err});
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
    if (we) chk("wr_first_cycle_valids", {30'd0, axi.aw_valid, axi.w_valid}, 32'd3);
    else    chk("rd_first_cycle_valid", {31'd0, axi.ar_valid}, 32'd1);
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (rsp_q.size() == 0) break;
    end
    if (rsp_q.size() != 0) begin fail("rsp_timeout"); rsp_q.delete(); end
    @(negedge clk_i);
  endtask

  initial begin
    int n;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
    aw_stall = 0; bresp_inj = 2'b00; rresp_inj = 2'b00; r_hold = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;
    mem[8'h41] = 32'hAABBCCDD;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", {31'd0, gnt_o}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_valids", {29'd0, axi.aw_valid, axi.w_valid, axi.ar_valid}, 32'd0);
    chk("rst_readies", {30'd0, axi.b_ready, axi.r_ready}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    obi_xfer(1'b0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_done();

    obi_xfer(1'b1, 32'h104, 4'b0011, 32'h12345678, 32'h0, 1'b0, 1'b1);
    wait_done();
    obi_xfer(1'b0, 32'h104, 4'hF, 32'h0, 32'hAABB5678, 1'b0, 1'b1);
    wait_done();

    aw_stall = 3;
    obi_xfer(1'b1, 32'h10C, 4'hF, 32'h55AA55AA, 32'h0, 1'b0, 1'b1);
    wait_done();
    obi_xfer(1'b0, 32'h10C, 4'hF, 32'h0, 32'h55AA55AA, 1'b0, 1'b1);
    wait_done();

    // Back-to-back: req_i stays high from a read into a write
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; be_i = 4'hF; wdata_i = 32'h0;
    for (n = 0; n < 50; n++) begin @(negedge clk_i); if (gnt_o) break; end
    if (n == 50) fail("b2b_gnt1_timeout");
    axi_q.push_back('{addr: 32'h100, strb: 4'hF, data: 32'h0});
    rsp_q.push_back('{chk_data: 1'b1, rdata: 32'hDEADBEEF, err: 1'b0});
    @(posedge clk_i); #1;
    we_i = 1'b1; addr_i = 32'h108; wdata_i = 32'hCAFEF00D;
    for (n = 0; n < 50; n++) begin @(negedge clk_i); if (gnt_o) break; end
    if (n == 50) fail("b2b_gnt2_timeout");
    chk("b2b_gnt_with_rvalid", {31'd0, rvalid_o}, 32'd1);
    axi_q.push_back('{addr: 32'h108, strb: 4'hF, data: 32'hCAFEF00D});
    rsp_q.push_back('{chk_data: 1'b0, rdata: 32'h0, err: 1'b0});
    @(posedge clk_i); #1;
    req_i = 1'b0;
    wait_done();
    obi_xfer(1'b0, 32'h108, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    wait_done();

    // Error responses; unaligned byte address must reach AXI word-aligned
    rresp_inj = AXI_RESP_SLVERR;
    obi_xfer(1'b0, 32'h102, 4'hF, 32'h0, 32'hDEADBEEF, ERR_EXP, 1'b1);
    wait_done();
    rresp_inj = AXI_RESP_OKAY;
    bresp_inj = AXI_RESP_DECERR;
    obi_xfer(1'b1, 32'h110, 4'hF, 32'h0BADF00D, 32'h0, ERR_EXP, 1'b1);
    wait_done();
    bresp_inj = AXI_RESP_OKAY;

    // Reset while waiting for read data: no OBI response may follow
    r_hold = 1'b1;
    obi_xfer(1'b0, 32'h100, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
    for (n = 0; n < 50; n++) begin @(negedge clk_i); if (axi.r_ready) break; end
    if (n == 50) fail("rd_rsp_timeout");
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    r_hold = 1'b0;
    @(negedge clk_i);
    chk("midrst_valids", {29'd0, axi.aw_valid, axi.w_valid, axi.ar_valid}, 32'd0);
    chk("midrst_readies", {30'd0, axi.b_ready, axi.r_ready}, 32'd0);
    chk("midrst_state", {29'd0, dut.state_q}, {29'd0, IDLE});
    chk("midrst_rvalid", {31'd0, rvalid_o}, 32'd0);
    repeat (10) @(negedge clk_i);

    obi_xfer(1'b0, 32'h104, 4'hF, 32'h0, 32'hAABB5678, 1'b0, 1'b1);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
